// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default widths, the address-window
// select value for the NIC, the NIC register map and a small helper used to size
// the return tracker.
package load_store_unit_pkg;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefRdW   = 5;

  // Request address top two bits equal to this value select the NIC window.
  localparam logic [1:0] NicSelDef = 2'b11;

  // NIC register map (request address low bits).
  localparam logic [1:0] NicRegTx     = 2'b00;
  localparam logic [1:0] NicRegStatus = 2'b10;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of every non-clock signal of the load/store unit.
//   req_*      : request from the EX stage, stall back to the pipeline
//   mem_*      : data-memory port (mem_d_in is read data from the memory)
//   nic_*      : NIC register port (nic_d_in is read data from the NIC)
//   wb_*       : register-file writeback
// slave  : the load/store unit itself.
// master : its environment (pipeline, memory and NIC together).
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DataW = DefDataW,
  parameter int unsigned ImmW  = 16,
  parameter int unsigned AddrW = 32,
  parameter int unsigned RdW   = DefRdW,
  parameter int unsigned NicAw = 2
) ();

  logic             req_valid;
  logic             req_ld;
  logic             req_sd;
  logic [ImmW-1:0]  req_addr;
  logic [DataW-1:0] req_data;
  logic [RdW-1:0]   req_rd;
  logic             stall;

  logic             mem_en;
  logic             mem_wr_en;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_d_out;
  logic [DataW-1:0] mem_d_in;

  logic             nic_en;
  logic             nic_wr_en;
  logic [NicAw-1:0] nic_addr;
  logic [DataW-1:0] nic_d_out;
  logic [DataW-1:0] nic_d_in;

  logic             wb_valid;
  logic [RdW-1:0]   wb_rd;
  logic [DataW-1:0] wb_data;

  modport slave (
    input  req_valid, req_ld, req_sd, req_addr, req_data, req_rd, mem_d_in, nic_d_in,
    output stall, mem_en, mem_wr_en, mem_addr, mem_d_out,
    output nic_en, nic_wr_en, nic_addr, nic_d_out, wb_valid, wb_rd, wb_data
  );

  modport master (
    output req_valid, req_ld, req_sd, req_addr, req_data, req_rd, mem_d_in, nic_d_in,
    input  stall, mem_en, mem_wr_en, mem_addr, mem_d_out,
    input  nic_en, nic_wr_en, nic_addr, nic_d_out, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/load_store_unit_return_tracker.sv
// In-flight load tracker and writeback register.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i         : record a newly accepted load
//   push_slot_i    : slot it enters (its return latency)
//   push_rd_i      : destination register
//   push_nic_i     : load targets the NIC (selects return data)
//   query_slot_i   : slot to test for occupancy
//   busy_o         : queried slot is occupied (0 for indices past the end)
//   mem_d_i/nic_d_i: read data from the two targets
//   wb_valid_o/wb_rd_o/wb_data_o : registered writeback
// Slot i in the current cycle returns its data at the end of cycle +i; the whole
// array shifts one place toward 0 every cycle.
module load_store_unit_return_tracker #(
  parameter int unsigned MaxL  = 2,
  parameter int unsigned RdW   = 5,
  parameter int unsigned DataW = 64,
  localparam int unsigned SlotW = $clog2(MaxL),
  localparam int unsigned QryW  = $clog2(MaxL + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [SlotW-1:0] push_slot_i,
  input  logic [RdW-1:0]   push_rd_i,
  input  logic             push_nic_i,
  input  logic [QryW-1:0]  query_slot_i,
  output logic             busy_o,
  input  logic [DataW-1:0] mem_d_i,
  input  logic [DataW-1:0] nic_d_i,
  output logic             wb_valid_o,
  output logic [RdW-1:0]   wb_rd_o,
  output logic [DataW-1:0] wb_data_o
);

  typedef struct packed {
    logic           valid;
    logic           is_nic;
    logic [RdW-1:0] rd;
  } slot_t;

  slot_t [MaxL-1:0] slot_q, slot_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RdW-1:0]   wb_rd_q, wb_rd_d;
  logic [DataW-1:0] wb_data_q, wb_data_d;

  // A slot index of MaxL would be the longest latency one cycle later, which no
  // push ever reaches, so it always reads as free.
  always_comb begin
    busy_o = 1'b0;
    if (query_slot_i < QryW'(MaxL)) begin
      busy_o = slot_q[query_slot_i[SlotW-1:0]].valid;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(MaxL) - 1; i++) begin
      slot_d[i] = slot_q[i + 1];
    end
    slot_d[MaxL-1] = '0;
    if (push_i) begin
      slot_d[push_slot_i] = '{valid: 1'b1, is_nic: push_nic_i, rd: push_rd_i};
    end

    wb_valid_d = slot_q[0].valid;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (slot_q[0].valid) begin
      wb_rd_d   = slot_q[0].rd;
      wb_data_d = slot_q[0].is_nic ? nic_d_i : mem_d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      slot_q     <= slot_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes one request per cycle into the data memory or the NIC
// register window, drives both targets from registers and returns load data to
// writeback in order, stalling a load whose return would collide with one in flight.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus_io : request, memory, NIC and writeback signals (slave side)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DataW  = DefDataW,
  parameter int unsigned ImmW   = 16,
  parameter int unsigned AddrW  = 32,
  parameter int unsigned RdW    = DefRdW,
  parameter int unsigned NicAw  = 2,
  parameter logic [1:0]  NicSel = NicSelDef,
  parameter int unsigned MemLat = 1,
  parameter int unsigned NicLat = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  load_store_unit_if.slave bus_io
);

  localparam int unsigned MaxL  = max_lat(MemLat, NicLat) + 1;
  localparam int unsigned SlotW = $clog2(MaxL);
  localparam int unsigned QryW  = $clog2(MaxL + 1);

  logic             is_nic, accept, slot_busy, stall;
  logic [SlotW-1:0] push_slot;
  logic [QryW-1:0]  query_slot;

  logic             mem_en_q, mem_en_d, mem_wr_en_q, mem_wr_en_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [DataW-1:0] mem_d_out_q, mem_d_out_d;
  logic             nic_en_q, nic_en_d, nic_wr_en_q, nic_wr_en_d;
  logic [NicAw-1:0] nic_addr_q, nic_addr_d;
  logic [DataW-1:0] nic_d_out_q, nic_d_out_d;

  assign is_nic = (bus_io.req_addr[ImmW-1 -: 2] == NicSel);

  // A load of latency L lands where slot L+1 sits now; if that is taken the
  // two returns would meet in the same cycle.
  assign push_slot  = is_nic ? SlotW'(NicLat) : SlotW'(MemLat);
  assign query_slot = is_nic ? QryW'(NicLat + 1) : QryW'(MemLat + 1);

  assign stall  = !rst_i & bus_io.req_valid & bus_io.req_ld & slot_busy;
  assign accept = !rst_i & bus_io.req_valid & (bus_io.req_ld | bus_io.req_sd) & !stall;
  assign bus_io.stall = stall;

  always_comb begin
    mem_en_d    = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_d_out_d = mem_d_out_q;
    nic_en_d    = 1'b0;
    nic_wr_en_d = 1'b0;
    nic_addr_d  = nic_addr_q;
    nic_d_out_d = nic_d_out_q;
    if (accept) begin
      // ld and sd together count as a load
      if (is_nic) begin
        nic_en_d    = 1'b1;
        nic_wr_en_d = !bus_io.req_ld;
        nic_addr_d  = bus_io.req_addr[NicAw-1:0];
        nic_d_out_d = bus_io.req_data;
      end else begin
        mem_en_d    = 1'b1;
        mem_wr_en_d = !bus_io.req_ld;
        mem_addr_d  = AddrW'(bus_io.req_addr);
        mem_d_out_d = bus_io.req_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_out_q <= '0;
      nic_en_q    <= 1'b0;
      nic_wr_en_q <= 1'b0;
      nic_addr_q  <= '0;
      nic_d_out_q <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_out_q <= mem_d_out_d;
      nic_en_q    <= nic_en_d;
      nic_wr_en_q <= nic_wr_en_d;
      nic_addr_q  <= nic_addr_d;
      nic_d_out_q <= nic_d_out_d;
    end
  end

  assign bus_io.mem_en    = mem_en_q;
  assign bus_io.mem_wr_en = mem_wr_en_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_d_out = mem_d_out_q;
  assign bus_io.nic_en    = nic_en_q;
  assign bus_io.nic_wr_en = nic_wr_en_q;
  assign bus_io.nic_addr  = nic_addr_q;
  assign bus_io.nic_d_out = nic_d_out_q;

  load_store_unit_return_tracker #(
    .MaxL (MaxL),
    .RdW  (RdW),
    .DataW(DataW)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept & bus_io.req_ld),
    .push_slot_i (push_slot),
    .push_rd_i   (bus_io.req_rd),
    .push_nic_i  (is_nic),
    .query_slot_i(query_slot),
    .busy_o      (slot_busy),
    .mem_d_i     (bus_io.mem_d_in),
    .nic_d_i     (bus_io.nic_d_in),
    .wb_valid_o  (bus_io.wb_valid),
    .wb_rd_o     (bus_io.wb_rd),
    .wb_data_o   (bus_io.wb_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with MemLat=3, NicLat=1. Loads are pushed to a
// scoreboard with their due writeback cycle when accepted; a per-cycle monitor
// checks port registers, stall and writeback against it.
module tb_load_store_unit;

  localparam int unsigned DataW  = 64;
  localparam int unsigned ImmW   = 16;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned RdW    = 5;
  localparam int unsigned NicAw  = 2;
  localparam int unsigned MemLat = 3;
  localparam int unsigned NicLat = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(
    .DataW(DataW), .ImmW(ImmW), .AddrW(AddrW), .RdW(RdW), .NicAw(NicAw)
  ) bus ();

  load_store_unit #(
    .DataW (DataW),
    .ImmW  (ImmW),
    .AddrW (AddrW),
    .RdW   (RdW),
    .NicAw (NicAw),
    .NicSel(2'b11),
    .MemLat(MemLat),
    .NicLat(NicLat)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 64'hA5;
    return {32'hF00D_0000, a};
  endfunction

  function automatic logic [63:0] nic_val(input logic [1:0] a);
    return 64'h4E1C_0000_0000_0000 | {62'd0, a};
  endfunction

  // Target models: read data valid only in the single cycle L after the enable.
  logic        hv_m [4];
  logic [31:0] ha_m [4];
  logic        hv_n [4];
  logic [1:0]  ha_n [4];

  always @(negedge clk) begin
    hv_m[0] <= (bus.mem_en === 1'b1) && (bus.mem_wr_en === 1'b0);
    ha_m[0] <= bus.mem_addr;
    hv_n[0] <= (bus.nic_en === 1'b1) && (bus.nic_wr_en === 1'b0);
    ha_n[0] <= bus.nic_addr;
    for (int k = 1; k < 4; k++) begin
      hv_m[k] <= hv_m[k-1];
      ha_m[k] <= ha_m[k-1];
      hv_n[k] <= hv_n[k-1];
      ha_n[k] <= ha_n[k-1];
    end
    bus.mem_d_in <= (hv_m[MemLat-1] === 1'b1) ? mem_val(ha_m[MemLat-1]) : 64'hDEAD_BEEF_0BAD_F00D;
    bus.nic_d_in <= (hv_n[NicLat-1] === 1'b1) ? nic_val(ha_n[NicLat-1]) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_exp_t;

  typedef struct {
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [63:0] mem_dout;
    logic        nic_en;
    logic        nic_wr;
    logic [1:0]  nic_addr;
    logic [63:0] nic_dout;
  } port_t;

  wb_exp_t sb[$];
  port_t   cur;
  bit      mon_en = 0;
  bit      last_acc;

  function automatic bit sb_busy(input int due);
    foreach (sb[i]) if (sb[i].due == due) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int    idx;
    logic  nic_q;
    int    lat;
    logic  exp_stall, acc;
    port_t nxt;
    if (!mon_en) begin
      cur      = '{default: '0};
      last_acc = 1'b0;
    end else begin
      check_eq("mem_en", bus.mem_en, cur.mem_en);
      check_eq("mem_wr_en", bus.mem_wr_en, cur.mem_wr);
      check_eq("mem_addr", bus.mem_addr, cur.mem_addr);
      check_eq("mem_d_out", bus.mem_d_out, cur.mem_dout);
      check_eq("nic_en", bus.nic_en, cur.nic_en);
      check_eq("nic_wr_en", bus.nic_wr_en, cur.nic_wr);
      check_eq("nic_addr", bus.nic_addr, cur.nic_addr);
      check_eq("nic_d_out", bus.nic_d_out, cur.nic_dout);

      idx = -1;
      foreach (sb[i]) if (sb[i].due == cyc) idx = i;
      if (idx >= 0) begin
        check_eq("wb_valid", bus.wb_valid, 1'b1);
        check_eq("wb_rd", bus.wb_rd, sb[idx].rd);
        check_eq("wb_data", bus.wb_data, sb[idx].data);
        sb.delete(idx);
      end else begin
        check_eq("wb_valid_idle", bus.wb_valid, 1'b0);
      end

      nic_q     = (bus.req_addr[15:14] == 2'b11);
      lat       = nic_q ? NicLat : MemLat;
      exp_stall = !rst && bus.req_valid && bus.req_ld && sb_busy(cyc + 2 + lat);
      check_eq("stall", bus.stall, exp_stall);
      acc = !rst && bus.req_valid && (bus.req_ld || bus.req_sd) && !exp_stall;

      nxt        = cur;
      nxt.mem_en = 1'b0;
      nxt.mem_wr = 1'b0;
      nxt.nic_en = 1'b0;
      nxt.nic_wr = 1'b0;
      if (rst) begin
        nxt = '{default: '0};
        sb.delete();
      end else if (acc) begin
        if (nic_q) begin
          nxt.nic_en   = 1'b1;
          nxt.nic_wr   = !bus.req_ld;
          nxt.nic_addr = bus.req_addr[1:0];
          nxt.nic_dout = bus.req_data;
        end else begin
          nxt.mem_en   = 1'b1;
          nxt.mem_wr   = !bus.req_ld;
          nxt.mem_addr = {16'h0, bus.req_addr};
          nxt.mem_dout = bus.req_data;
        end
        if (bus.req_ld) begin
          sb.push_back('{due: cyc + 2 + lat, rd: bus.req_rd,
                         data: nic_q ? nic_val(bus.req_addr[1:0]) : mem_val({16'h0, bus.req_addr})});
        end
      end
      last_acc = acc;
      cur      = nxt;
    end
  end

  task automatic clear_req();
    bus.req_valid = 1'b0;
    bus.req_ld    = 1'b0;
    bus.req_sd    = 1'b0;
  endtask

  // Holds the request until accepted; returns the acceptance cycle.
  task automatic issue(input logic ld, input logic sd, input logic [15:0] addr,
                       input logic [63:0] data, input logic [4:0] rd, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc       = -1;
    bus.req_valid = 1'b1;
    bus.req_ld    = ld;
    bus.req_sd    = sd;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_rd    = rd;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      #1;
      if (last_acc) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    check_eq("accepted", done, 1'b1);
    clear_req();
  endtask

  task automatic idle(input int n);
    clear_req();
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1;
    int tp;
    // Reset held for two edges with a live load request.
    rst          = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_ld    = 1'b1;
    bus.req_sd    = 1'b0;
    bus.req_addr  = 16'h0010;
    bus.req_data  = 64'h0;
    bus.req_rd    = 5'd7;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_req();
    idle(1);

    // Memory load (wb at T+5) and NIC load (wb at T+3).
    issue(1'b1, 1'b0, 16'h0010, 64'h0, 5'd3, t0);
    idle(7);
    issue(1'b1, 1'b0, 16'hC002, 64'h0, 5'd9, t0);
    idle(5);

    // Stores, a load+store request, and a request with no flag.
    issue(1'b0, 1'b1, 16'hC001, 64'h55, 5'd0, t0);
    idle(3);
    issue(1'b0, 1'b1, 16'h0123, 64'h1234, 5'd0, t0);
    issue(1'b1, 1'b1, 16'h0040, 64'h77, 5'd6, t0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0010;
    @(posedge clk);
    #1;
    idle(6);

    // Memory load then NIC load two cycles later: one stall cycle.
    issue(1'b1, 1'b0, 16'h0020, 64'h0, 5'd10, t0);
    idle(1);
    issue(1'b1, 1'b0, 16'hC003, 64'h0, 5'd11, t1);
    check_eq("nic_accept_delay", t1 - t0, 3);
    idle(7);

    // Four back-to-back memory loads, then four NIC loads.
    tp = -1;
    for (int i = 1; i <= 4; i++) begin
      issue(1'b1, 1'b0, 16'h0100 + 16'(i), 64'h0, 5'(i), t0);
      if (tp >= 0) check_eq("b2b_mem", t0 - tp, 1);
      tp = t0;
    end
    tp = -1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 16'hC000 + 16'(i), 64'h0, 5'(20 + i), t0);
      if (tp >= 0) check_eq("b2b_nic", t0 - tp, 1);
      tp = t0;
    end
    idle(7);

    // Reset one cycle after an accepted load drops it.
    issue(1'b1, 1'b0, 16'h0030, 64'h0, 5'd12, t0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    issue(1'b1, 1'b0, 16'h0031, 64'h0, 5'd13, t0);
    idle(7);

    // Random mix of loads and stores to both targets.
    for (int i = 0; i < 40; i++) begin
      logic        ld, sd, nic;
      logic [15:0] a;
      ld  = 1'($urandom_range(0, 2) != 0);
      sd  = !ld || (($urandom_range(0, 7)) == 0);
      nic = 1'($urandom_range(0, 1));
      a   = nic ? {2'b11, 12'h0, 2'($urandom_range(0, 3))} : {1'b0, 15'($urandom)};
      issue(ld, sd, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)), t0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(8);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
